// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding unit: tracks in-flight register writers in a tag
// pipeline, stalls decode on load-use hazards and drives registered forwarding selects.
module hazard_scoreboard #(
  parameter  int XLEN        = 32,
  parameter  int AW          = 5,
  parameter  int DEPTH       = 3,
  parameter  int LOAD_SRC    = 1,
  parameter  int FLUSH_DEPTH = 1,
  localparam int SW          = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [AW-1:0]         id_rs1_i,
  input  logic [AW-1:0]         id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [AW-1:0]         id_rd_i,
  input  logic                  id_reg_wr_en_i,
  input  logic                  id_is_load_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic [DEPTH*XLEN-1:0] stage_data_i,
  input  logic [XLEN-1:0]       ex_rs1_data_i,
  input  logic [XLEN-1:0]       ex_rs2_data_i,
  output logic                  stall_o,
  output logic                  issue_o,
  output logic                  ex_valid_o,
  output logic [SW-1:0]         ex_fwd_sel1_o,
  output logic [SW-1:0]         ex_fwd_sel2_o,
  output logic [XLEN-1:0]       ex_op1_o,
  output logic [XLEN-1:0]       ex_op2_o,
  output logic [31:0]           stall_count_o
);

  logic [DEPTH-1:0] tag_valid;
  logic [DEPTH-1:0] tag_wr;
  logic [DEPTH-1:0] tag_load;
  logic [AW-1:0]    tag_rd [DEPTH];

  logic [SW-1:0] sel1_d;
  logic [SW-1:0] sel2_d;
  logic          hz1;
  logic          hz2;

  // Scanning from oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    sel1_d = '0;
    sel2_d = '0;
    hz1    = 1'b0;
    hz2    = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (tag_valid[k] && tag_wr[k] && tag_rd[k] == id_rs1_i &&
          id_rs1_i != '0 && id_rs1_used_i) begin
        sel1_d = SW'(k + 1);
        hz1    = tag_load[k] && (k < LOAD_SRC);
      end
      if (tag_valid[k] && tag_wr[k] && tag_rd[k] == id_rs2_i &&
          id_rs2_i != '0 && id_rs2_used_i) begin
        sel2_d = SW'(k + 1);
        hz2    = tag_load[k] && (k < LOAD_SRC);
      end
    end
  end

  assign stall_o = id_valid_i & (hz1 | hz2) & ~flush_i;
  assign issue_o = id_valid_i & ~stall_o & ~hold_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid     <= '0;
      tag_wr        <= '0;
      tag_load      <= '0;
      for (int k = 0; k < DEPTH; k++) tag_rd[k] <= '0;
      ex_valid_o    <= 1'b0;
      ex_fwd_sel1_o <= '0;
      ex_fwd_sel2_o <= '0;
      stall_count_o <= '0;
    end else if (flush_i || !hold_i) begin
      for (int k = 1; k < DEPTH; k++) begin
        tag_wr[k]    <= tag_wr[k-1];
        tag_load[k]  <= tag_load[k-1];
        tag_rd[k]    <= tag_rd[k-1];
        // A flush also kills the younger shifted entries that were on the wrong path.
        tag_valid[k] <= (flush_i && k < FLUSH_DEPTH) ? 1'b0 : tag_valid[k-1];
      end
      tag_valid[0]  <= issue_o;
      tag_wr[0]     <= id_reg_wr_en_i;
      tag_load[0]   <= id_is_load_i;
      tag_rd[0]     <= id_rd_i;
      ex_valid_o    <= issue_o;
      ex_fwd_sel1_o <= issue_o ? sel1_d : '0;
      ex_fwd_sel2_o <= issue_o ? sel2_d : '0;
      if (stall_o && !hold_i && stall_count_o != 32'hFFFF_FFFF)
        stall_count_o <= stall_count_o + 32'd1;
    end
  end

  always_comb begin
    ex_op1_o = ex_rs1_data_i;
    ex_op2_o = ex_rs2_data_i;
    for (int k = 0; k < DEPTH; k++) begin
      if (ex_fwd_sel1_o == SW'(k + 1)) ex_op1_o = stage_data_i[k*XLEN +: XLEN];
      if (ex_fwd_sel2_o == SW'(k + 1)) ex_op2_o = stage_data_i[k*XLEN +: XLEN];
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected EX state is queued per decode cycle
// and compared one clock later against the DUT.
module tb_hazard_scoreboard;

  localparam logic [31:0] S0  = 32'hAAAA_0001;
  localparam logic [31:0] S1  = 32'hBBBB_0002;
  localparam logic [31:0] S2  = 32'hCCCC_0003;
  localparam logic [31:0] RF1 = 32'h1111_1111;
  localparam logic [31:0] RF2 = 32'h2222_2222;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, id_rs1_used_i, id_rs2_used_i, id_reg_wr_en_i, id_is_load_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        hold_i, flush_i;
  logic [95:0] stage_data_i;
  logic [31:0] ex_rs1_data_i, ex_rs2_data_i;
  logic        stall_o, issue_o, ex_valid_o;
  logic [1:0]  ex_fwd_sel1_o, ex_fwd_sel2_o;
  logic [31:0] ex_op1_o, ex_op2_o, stall_count_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       valid;
    logic [1:0] s1;
    logic [1:0] s2;
  } ex_exp_t;

  ex_exp_t sb[$];

  hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rd_i(id_rd_i), .id_reg_wr_en_i(id_reg_wr_en_i), .id_is_load_i(id_is_load_i),
    .hold_i(hold_i), .flush_i(flush_i), .stage_data_i(stage_data_i),
    .ex_rs1_data_i(ex_rs1_data_i), .ex_rs2_data_i(ex_rs2_data_i),
    .stall_o(stall_o), .issue_o(issue_o), .ex_valid_o(ex_valid_o),
    .ex_fwd_sel1_o(ex_fwd_sel1_o), .ex_fwd_sel2_o(ex_fwd_sel2_o),
    .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .stall_count_o(stall_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] op_for(input logic [1:0] sel, input logic [31:0] rf);
    case (sel)
      2'd1:    return S0;
      2'd2:    return S1;
      2'd3:    return S2;
      default: return rf;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic v,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic wr, input logic ld, input logic hold,
                               input logic flush, input logic exp_stall,
                               input logic exp_issue, input logic exp_valid,
                               input logic [1:0] exp_s1, input logic [1:0] exp_s2);
    ex_exp_t e;
    id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2;
    id_rs1_used_i = u1; id_rs2_used_i = u2; id_rd_i = rd;
    id_reg_wr_en_i = wr; id_is_load_i = ld; hold_i = hold; flush_i = flush;
    #1;
    checkOutput({tag, ".stall"}, 32'(stall_o), 32'(exp_stall));
    checkOutput({tag, ".issue"}, 32'(issue_o), 32'(exp_issue));
    e.valid = exp_valid; e.s1 = exp_s1; e.s2 = exp_s2;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checkOutput({tag, ".ex_valid"}, 32'(ex_valid_o), 32'(e.valid));
    checkOutput({tag, ".sel1"}, 32'(ex_fwd_sel1_o), 32'(e.s1));
    checkOutput({tag, ".sel2"}, 32'(ex_fwd_sel2_o), 32'(e.s2));
    checkOutput({tag, ".op1"}, ex_op1_o, op_for(e.s1, RF1));
    checkOutput({tag, ".op2"}, ex_op2_o, op_for(e.s2, RF2));
  endtask

  task automatic alu(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [1:0] s1, input logic [1:0] s2);
    applyStimulus(tag, 1, rs1, rs2, 1, 1, rd, 1, 0, 0, 0, 0, 1, 1, s1, s2);
  endtask

  task automatic load(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [1:0] s1);
    applyStimulus(tag, 1, rs1, 5'd0, 1, 0, rd, 1, 1, 0, 0, 0, 1, 1, s1, 2'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++)
      applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
  endtask

  initial begin
    stage_data_i = {S2, S1, S0};
    ex_rs1_data_i = RF1; ex_rs2_data_i = RF2;
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
    id_rd_i = 0; id_reg_wr_en_i = 0; id_is_load_i = 0; hold_i = 0; flush_i = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst.ex_valid", 32'(ex_valid_o), 32'd0);
    checkOutput("rst.sel1", 32'(ex_fwd_sel1_o), 32'd0);
    checkOutput("rst.count", stall_count_o, 32'd0);
    checkOutput("rst.op1", ex_op1_o, RF1);
    checkOutput("rst.op2", ex_op2_o, RF2);

    $display("[TB] back-to-back ALU");
    alu("b2b_p", 1, 2, 3, 0, 0);
    alu("b2b_c", 4, 1, 5, 1, 0);
    drain();

    $display("[TB] forwarding distance");
    alu("d2_p", 1, 2, 3, 0, 0);
    alu("d2_i", 10, 8, 9, 0, 0);
    alu("d2_c", 4, 1, 5, 2, 0);
    drain();
    alu("d3_p", 1, 2, 3, 0, 0);
    alu("d3_i1", 10, 8, 9, 0, 0);
    alu("d3_i2", 11, 8, 9, 0, 0);
    alu("d3_c", 4, 1, 5, 3, 0);
    drain();
    alu("d4_p", 1, 2, 3, 0, 0);
    alu("d4_i1", 10, 8, 9, 0, 0);
    alu("d4_i2", 11, 8, 9, 0, 0);
    alu("d4_i3", 12, 8, 9, 0, 0);
    alu("d4_c", 4, 1, 5, 0, 0);
    drain();

    $display("[TB] load-use");
    load("lu_ld", 1, 2, 0);
    applyStimulus("lu_stall", 1, 1, 1, 1, 1, 4, 1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0);
    checkOutput("lu.count_after_stall", stall_count_o, 32'd1);
    applyStimulus("lu_issue", 1, 1, 1, 1, 1, 4, 1, 0, 0, 0, 0, 1, 1, 2'd2, 2'd2);
    checkOutput("lu.count_after_issue", stall_count_o, 32'd1);
    drain();

    $display("[TB] youngest wins, x0 and unused sources");
    alu("yw_a", 1, 2, 3, 0, 0);
    alu("yw_b", 1, 2, 3, 0, 0);
    alu("yw_c", 6, 1, 0, 1, 0);
    drain();
    load("r0_ld", 0, 2, 0);
    alu("r0_use", 7, 0, 3, 0, 0);
    drain();
    load("un_ld", 1, 2, 0);
    applyStimulus("un_use", 1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0);
    drain();

    $display("[TB] flush during stall");
    load("fl_ld", 1, 2, 0);
    applyStimulus("fl_kill", 1, 1, 2, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0);
    checkOutput("fl.count", stall_count_o, 32'd1);
    applyStimulus("fl_redo", 1, 1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 1, 1, 2'd2, 2'd0);
    drain();

    $display("[TB] hold then reset");
    alu("hd_p", 2, 8, 9, 0, 0);
    load("hd_ld", 1, 2, 1);
    for (int i = 0; i < 3; i++)
      applyStimulus("hd_hold", 1, 1, 2, 1, 1, 4, 1, 0, 1, 0, 1, 0, 1, 2'd1, 2'd0);
    checkOutput("hd.count", stall_count_o, 32'd1);
    hold_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("hr.ex_valid", 32'(ex_valid_o), 32'd0);
    checkOutput("hr.sel1", 32'(ex_fwd_sel1_o), 32'd0);
    checkOutput("hr.sel2", 32'(ex_fwd_sel2_o), 32'd0);
    checkOutput("hr.count", stall_count_o, 32'd0);
    checkOutput("hr.op1", ex_op1_o, RF1);
    applyStimulus("post_rst", 1, 1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard detection and forwarding unit for the in-order RISC-V pipeline. It tracks in-flight register writers in an internal tag pipeline, stalls decode on load-use hazards, and absorbs branch flushes and external hold. It drives registered forwarding selects and forwarded operands into the execute stage. It supersedes the hard-coded two-source forwarding logic with a configurable depth and load-latency model.

Parameters:
XLEN, 32, datapath width
AW, 5, register index width; index 0 is hardwired zero
DEPTH, 3, tracked stages after decode; entry 0 = EX, entry DEPTH-1 = last stage before the regfile write is visible
LOAD_SRC, 1, lowest forwarding source index at which load data exists
FLUSH_DEPTH, 1, number of youngest tag entries killed by flush_i (1..DEPTH)
SW, $clog2(DEPTH+1), forwarding select width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
id_valid_i  in  1  decode holds a valid instruction
id_rs1_i / id_rs2_i  in  AW  decode source registers
id_rs1_used_i / id_rs2_used_i  in  1  source is actually read (no false stalls for U/J-type etc.)
id_rd_i  in  AW  decode destination
id_reg_wr_en_i  in  1  decode instruction writes rd
id_is_load_i  in  1  decode instruction is a load
hold_i  in  1  external freeze (e.g. memory wait)
flush_i  in  1  branch taken: kill decode and the FLUSH_DEPTH youngest entries
stage_data_i  in  DEPTH*XLEN  slice k = result bus of stage EX+1+k
ex_rs1_data_i / ex_rs2_data_i  in  XLEN  regfile values already registered into EX
stall_o  out  1  decode must hold; comb
issue_o  out  1  decode instruction advances into EX this cycle; comb
ex_valid_o  out  1  EX holds an issued instruction
ex_fwd_sel1_o / ex_fwd_sel2_o  out  SW  0 = regfile, k+1 = stage_data_i slice k
ex_op1_o / ex_op2_o  out  XLEN  forwarded operands; comb mux of selects
stall_count_o  out  32  load-use stall cycles, saturating

Behaviour:
- Tag entry: {valid, rd, wr_en, is_load}. match(k, rs) = valid & wr_en & rd==rs & rs!=0 & used.
- Per source, the youngest match (lowest k) wins; no match -> sel 0.
- Load-use hazard: the youngest match has is_load and k < LOAD_SRC, for either source.
- stall_o = id_valid_i & hazard & ~flush_i. issue_o = id_valid_i & ~stall_o & ~hold_i & ~flush_i.
- Per clock, priority rst > flush_i > hold_i > normal:
  - rst: all entries invalid; ex_valid_o=0; selects=0; stall_count_o=0. Operand outputs then equal ex_rsN_data_i.
  - flush_i, taken even when hold_i=1: entries shift by one. New entry 0 is invalid. Shifted entries 1..FLUSH_DEPTH-1 are invalidated. ex_valid_o <= 0; selects <= 0.
  - hold_i (no flush): entries, ex_valid_o, selects and stall_count_o all hold.
  - normal: entry[k+1] <= entry[k]; entry[DEPTH-1] is discarded.
    - On issue, entry 0 <= decode fields; ex_valid_o <= 1; ex_fwd_selN_o <= youngest-match k+1, computed in decode.
    - Otherwise entry 0 is a bubble; ex_valid_o <= 0; selects <= 0.
- Select timing: a producer at entry k during decode is at entry k+1 when the consumer is in EX, so it is read from stage_data_i slice k.
- stall_count_o increments on each cycle with stall_o=1 and hold_i=0. It saturates at 0xFFFFFFFF.
- A stall inserts exactly (LOAD_SRC - k) bubbles before issue. With defaults and k=0 that is 1 bubble.
- Entries with is_load and k >= LOAD_SRC forward normally.
- rd=0 writers never match and never stall.
- Beyond DEPTH the regfile supplies the value (sel 0). The regfile must be write-visible by then.
- Sources with used=0 never match.

Test Plan:
- Back-to-back ALU, defaults: add x1,x2,x3 then add x4,x1,x5.
  -> no stall; second instruction in EX has ex_fwd_sel1_o=1 and ex_op1_o = slice 0.
- Distance 2 and 3: same producer with one and then two independent instructions between.
  -> sel=2 (slice 1), then sel=3 (slice 2); with three between, sel=0.
- Load-use: lw x1 then add x4,x1,x1.
  -> stall_o=1 for exactly 1 cycle; bubble in EX (ex_valid_o=0); on issue both sels=2; stall_count_o=1.
- Youngest wins: add x1; add x1; add x6,x1,x0.
  -> sel1=1 (not 2); sel2=0 because rs2=x0.
- Flush during stall: lw x1; add x4,x1,x2 stalled; flush_i=1 in that cycle.
  -> stall_o=0, issue_o=0; next cycle ex_valid_o=0 and entry 0 invalid; stall_count_o unchanged.
- Hold then rst: hold_i=1 for 3 cycles mid-hazard.
  -> selects, entries and count frozen; then rst=1 for 1 cycle -> all outputs 0, no matches against stale tags.
